// File: rtl/diag_window_gen_if.sv
// Stream bundle for diag_window_gen: raster-order {G, RB} samples in, diagonal-neighbour windows out.
// The master side drives samples; the slave side (the window generator) drives windows.
interface diag_window_gen_if #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_g;
  logic [DATA_W-1:0] in_rb;

  logic              out_valid;
  logic              out_eof;
  logic [RW-1:0]     out_row;
  logic [CW-1:0]     out_col;
  logic [DATA_W-1:0] G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1;
  logic [DATA_W-1:0] RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1;

  modport master (
    output in_valid, in_sof, in_g, in_rb,
    input  out_valid, out_eof, out_row, out_col,
    input  G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1,
    input  RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1
  );

  modport slave (
    input  in_valid, in_sof, in_g, in_rb,
    output out_valid, out_eof, out_row, out_col,
    output G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1,
    output RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1
  );
endinterface

// File: rtl/diag_window_gen.sv
// Diagonal 3x3-corner window generator: two cascaded line buffers plus 2-deep column delays
// per used row; one registered window per accepted pixel at (r>=2, c>=2).
module diag_window_gen #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input logic             clk,
  input logic             rst,
  diag_window_gen_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = 2 * DATA_W;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col, acol;
  logic [RW-1:0] row, arow;
  logic [PW-1:0] line_a [IMG_W];
  logic [PW-1:0] line_b [IMG_W];
  logic [PW-1:0] pix, a_rd, b_rd;
  logic [PW-1:0] cur_d1, cur_d2, top_d1, top_d2;
  logic          win_done;

  assign acol     = bus.in_sof ? '0 : col;
  assign arow     = bus.in_sof ? '0 : row;
  assign pix      = {bus.in_g, bus.in_rb};
  assign a_rd     = line_a[acol];
  assign b_rd     = line_b[acol];
  assign win_done = (arow >= RW'(2)) && (acol >= CW'(2));

  // Cascade: A holds row r-1, B holds row r-2; read-before-write at the same column.
  always_ff @(posedge clk) begin
    if (bus.in_valid && !rst) begin
      line_a[acol] <= pix;
      line_b[acol] <= a_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row          <= '0;
      col          <= '0;
      cur_d1       <= '0;
      cur_d2       <= '0;
      top_d1       <= '0;
      top_d2       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_eof  <= 1'b0;
      bus.out_row  <= '0;
      bus.out_col  <= '0;
      bus.G_m1_m1  <= '0;
      bus.G_m1_p1  <= '0;
      bus.G_p1_m1  <= '0;
      bus.G_p1_p1  <= '0;
      bus.RB_m1_m1 <= '0;
      bus.RB_m1_p1 <= '0;
      bus.RB_p1_m1 <= '0;
      bus.RB_p1_p1 <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_eof   <= 1'b0;
      if (bus.in_valid) begin
        if (acol == C_LAST) begin
          col <= '0;
          row <= (arow == R_LAST) ? '0 : arow + RW'(1);
        end else begin
          col <= acol + CW'(1);
          row <= arow;
        end
        cur_d1 <= pix;
        cur_d2 <= cur_d1;
        top_d1 <= b_rd;
        top_d2 <= top_d1;
        // Column delays are only trusted for c>=2, where both taps belong to this row.
        if (win_done) begin
          bus.out_valid <= 1'b1;
          bus.out_eof   <= (arow == R_LAST) && (acol == C_LAST);
          bus.out_row   <= arow - RW'(1);
          bus.out_col   <= acol - CW'(1);
          bus.G_m1_m1   <= top_d2[PW-1:DATA_W];
          bus.RB_m1_m1  <= top_d2[DATA_W-1:0];
          bus.G_m1_p1   <= b_rd[PW-1:DATA_W];
          bus.RB_m1_p1  <= b_rd[DATA_W-1:0];
          bus.G_p1_m1   <= cur_d2[PW-1:DATA_W];
          bus.RB_p1_m1  <= cur_d2[DATA_W-1:0];
          bus.G_p1_p1   <= bus.in_g;
          bus.RB_p1_p1  <= bus.in_rb;
        end
      end
    end
  end
endmodule

// File: tb/tb_diag_window_gen.sv
// Bench for diag_window_gen on an 8x6 image: whole-frame pixel array reference model,
// randomized data and valid gaps, directed boundary checks.
module tb_diag_window_gen;
  localparam int DW = 12;
  localparam int IW = 8;
  localparam int IH = 6;

  typedef struct packed {
    logic [2:0]        row;
    logic [2:0]        col;
    logic              eof;
    logic [3:0][11:0]  g;
    logic [3:0][11:0]  rb;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  diag_window_gen_if #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) bus ();
  diag_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  win_t obs_q[$];
  win_t exp_q[$];
  win_t ref_q[$];
  win_t cap_w;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [23:0] img [IH][IW];
  int   mr = 0;
  int   mc = 0;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      cap_w.row = bus.out_row;
      cap_w.col = bus.out_col;
      cap_w.eof = bus.out_eof;
      cap_w.g   = {bus.G_m1_m1, bus.G_m1_p1, bus.G_p1_m1, bus.G_p1_p1};
      cap_w.rb  = {bus.RB_m1_m1, bus.RB_m1_p1, bus.RB_p1_m1, bus.RB_p1_p1};
      obs_q.push_back(cap_w);
    end
  end

  // Reference: store every accepted pixel at its raster position, emit windows by definition.
  task automatic model_accept(input logic sof, input logic [11:0] g, input logic [11:0] rb);
    win_t w;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = {g, rb};
    if (mr >= 2 && mc >= 2) begin
      w.row = 3'(mr - 1);
      w.col = 3'(mc - 1);
      w.eof = (mr == IH - 1) && (mc == IW - 1);
      w.g   = {img[mr-2][mc-2][23:12], img[mr-2][mc][23:12], img[mr][mc-2][23:12], img[mr][mc][23:12]};
      w.rb  = {img[mr-2][mc-2][11:0], img[mr-2][mc][11:0], img[mr][mc-2][11:0], img[mr][mc][11:0]};
      exp_q.push_back(w);
    end
    mc++;
    if (mc == IW) begin
      mc = 0;
      mr++;
      if (mr == IH) mr = 0;
    end
  endtask

  task automatic step(input logic v, input logic sof, input logic [11:0] g, input logic [11:0] rb);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_g     = g;
    bus.in_rb    = rb;
    @(posedge clk);
    #1;
    if (v && !rst) model_accept(sof, g, rb);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic check_queues(input string tag);
    win_t o, e;
    step(1'b0, 1'b0, 12'h0, 12'h0);
    step(1'b0, 1'b0, 12'h0, 12'h0);
    n_cmp++;
    assert (obs_q.size() === exp_q.size()) else begin
      n_bad++;
      $error("FAIL %s window count: got %0d want %0d", tag, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      assert (o === e) else begin
        n_bad++;
        $error("FAIL %s window: got %h want %h", tag, o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // kind 0 = ramp, 1 = all 0xFFF, else random. Stops before (stop_r, stop_c).
  task automatic frame(input int kind, input int gap_pct, input bit sof_first, input bit chk_first,
                       input int stop_r = IH, input int stop_c = 0);
    logic [11:0] g, rb;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (r == stop_r && c == stop_c) return;
        while ($urandom_range(99) < gap_pct)
          step(1'b0, 1'($urandom_range(1)), 12'($urandom), 12'($urandom));
        case (kind)
          0:       begin g = 12'(16 * r + c); rb = 12'(2048 + 16 * r + c); end
          1:       begin g = 12'hFFF; rb = 12'hFFF; end
          default: begin g = 12'($urandom); rb = 12'($urandom); end
        endcase
        step(1'b1, sof_first && r == 0 && c == 0, g, rb);
        if (chk_first) begin
          if (r < 2 || (r == 2 && c < 2)) begin
            n_cmp++;
            assert (bus.out_valid === 1'b0) else begin
              n_bad++;
              $error("FAIL early_valid at (%0d,%0d): got %b want 0", r, c, bus.out_valid);
            end
          end else if (r == 2 && c == 2) begin
            n_cmp++;
            assert (bus.out_valid === 1'b1) else begin
              n_bad++;
              $error("FAIL first_valid: got %b want 1", bus.out_valid);
            end
            n_cmp++;
            assert ({bus.out_row, bus.out_col} === {3'd1, 3'd1}) else begin
              n_bad++;
              $error("FAIL first_rowcol: got %0d,%0d want 1,1", bus.out_row, bus.out_col);
            end
            if (kind == 0) begin
              n_cmp++;
              assert ({bus.G_m1_m1, bus.G_m1_p1, bus.G_p1_m1, bus.G_p1_p1} === 48'h000_002_020_022) else begin
                n_bad++;
                $error("FAIL first_g: got %h %h %h %h want 000 002 020 022",
                       bus.G_m1_m1, bus.G_m1_p1, bus.G_p1_m1, bus.G_p1_p1);
              end
              n_cmp++;
              assert ({bus.RB_m1_m1, bus.RB_m1_p1, bus.RB_p1_m1, bus.RB_p1_p1} === 48'h800_802_820_822) else begin
                n_bad++;
                $error("FAIL first_rb: got %h %h %h %h want 800 802 820 822",
                       bus.RB_m1_m1, bus.RB_m1_p1, bus.RB_p1_m1, bus.RB_p1_p1);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    n_cmp++;
    assert ({bus.out_valid, bus.out_eof, bus.out_row, bus.out_col} === 8'h00) else begin
      n_bad++;
      $error("FAIL %s ctl: got v=%b e=%b r=%0d c=%0d want all 0", tag,
             bus.out_valid, bus.out_eof, bus.out_row, bus.out_col);
    end
    n_cmp++;
    assert ({bus.G_m1_m1, bus.G_m1_p1, bus.G_p1_m1, bus.G_p1_p1,
             bus.RB_m1_m1, bus.RB_m1_p1, bus.RB_p1_m1, bus.RB_p1_p1} === 96'h0) else begin
      n_bad++;
      $error("FAIL %s data: got %h %h %h %h / %h %h %h %h want 0", tag,
             bus.G_m1_m1, bus.G_m1_p1, bus.G_p1_m1, bus.G_p1_p1,
             bus.RB_m1_m1, bus.RB_m1_p1, bus.RB_p1_m1, bus.RB_p1_p1);
    end
  endtask

  initial begin
    int n_eof;
    win_t eof_w;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_g     = '0;
    bus.in_rb    = '0;

    // Reset state
    rst = 1'b1;
    step(1'b0, 1'b0, 12'h0, 12'h0);
    step(1'b0, 1'b0, 12'h0, 12'h0);
    rst = 1'b0;
    check_zero_outputs("reset");

    // Gap-free ramp frame: latency, count, eof
    frame(0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 12'h0, 12'h0);
    step(1'b0, 1'b0, 12'h0, 12'h0);
    n_cmp++;
    assert (obs_q.size() === 24) else begin
      n_bad++;
      $error("FAIL ramp_count: got %0d want 24", obs_q.size());
    end
    n_eof = 0;
    eof_w = '0;
    foreach (obs_q[i]) if (obs_q[i].eof) begin n_eof++; eof_w = obs_q[i]; end
    n_cmp++;
    assert (n_eof === 1) else begin
      n_bad++;
      $error("FAIL ramp_eof_count: got %0d want 1", n_eof);
    end
    n_cmp++;
    assert ({eof_w.row, eof_w.col, eof_w.g[0]} === {3'd4, 3'd6, 12'h057}) else begin
      n_bad++;
      $error("FAIL ramp_eof_win: got r=%0d c=%0d g_p1_p1=%h want 4 6 057", eof_w.row, eof_w.col, eof_w.g[0]);
    end
    ref_q = obs_q;
    check_queues("ramp");

    // Same ramp with ~50% valid gaps must be bit-identical
    frame(0, 50, 1'b1, 1'b0);
    step(1'b0, 1'b0, 12'h0, 12'h0);
    step(1'b0, 1'b0, 12'h0, 12'h0);
    n_cmp++;
    assert (obs_q.size() === ref_q.size()) else begin
      n_bad++;
      $error("FAIL gap_count: got %0d want %0d", obs_q.size(), ref_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < ref_q.size(); i++) begin
      n_cmp++;
      assert (obs_q[i] === ref_q[i]) else begin
        n_bad++;
        $error("FAIL gap_win %0d: got %h want %h", i, obs_q[i], ref_q[i]);
      end
    end
    check_queues("ramp_gaps");

    // Random data, random gaps
    frame(2, 30, 1'b1, 1'b0);
    check_queues("random");

    // in_sof reasserted at (3,5): abandon partial frame, restart
    frame(2, 20, 1'b1, 1'b0, 3, 5);
    frame(0, 20, 1'b1, 1'b1);
    check_queues("mid_sof");

    // rst during row 3, then a frame without in_sof
    frame(2, 10, 1'b1, 1'b0, 3, 4);
    rst = 1'b1;
    step(1'b0, 1'b0, 12'h0, 12'h0);
    rst = 1'b0;
    check_zero_outputs("mid_rst");
    mr = 0;
    mc = 0;
    frame(2, 20, 1'b0, 1'b1);
    check_queues("post_rst");

    // Back-to-back frames, second all 0xFFF, counters wrap without in_sof
    frame(0, 0, 1'b1, 1'b0);
    frame(1, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 12'h0, 12'h0);
    step(1'b0, 1'b0, 12'h0, 12'h0);
    n_cmp++;
    assert (obs_q.size() === 48) else begin
      n_bad++;
      $error("FAIL b2b_count: got %0d want 48", obs_q.size());
    end
    for (int i = 24; i < obs_q.size(); i++) begin
      n_cmp++;
      assert ({obs_q[i].g, obs_q[i].rb} === {8{12'hFFF}}) else begin
        n_bad++;
        $error("FAIL b2b_fff %0d: got %h %h want all fff", i, obs_q[i].g, obs_q[i].rb);
      end
    end
    check_queues("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
